uart_receive: RTL and testbench
===============================

# uart_receive

Serial receiver for the 8N1 UART link used between the board and the host. Samples the asynchronous `rx` line, frames one start bit, eight data bits LSB first and one stop bit, each CLOCKS_PER_BIT clocks long. Presents each received byte as a one-cycle strobe. Sits on the input side of the serial path, opposite the existing transmitter, and feeds the game command decoder.

## Interface
- CLOCKS_PER_BIT, 10: clocks per serial bit; legal range 4..65535.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- rx  in  1  asynchronous serial input; idles high.
- rxdata  out  8  last correctly framed byte; holds its value until the next good frame.
- rxvalid  out  1  one-cycle pulse; rxdata is updated in the same cycle.
- rxerror  out  1  one-cycle pulse on a framing error (stop bit sampled low).
- rxbusy  out  1  high in every state other than IDLE.

## Operation
- Input path: two-flop synchronizer on rx, then a registered previous value for falling-edge detect. The synchronizer resets to 1.
- HALF = CLOCKS_PER_BIT/2, rounded down. The counter is $clog2(CLOCKS_PER_BIT) bits wide and counts down to 0.
- IDLE: when a falling edge is seen on the synced line, go to START with counter = HALF-1.
- START: at counter 0, if the synced line is low, go to DATA with counter = CLOCKS_PER_BIT-1 and bitidx = 0. Otherwise the low was a glitch: return to IDLE with no outputs.
- DATA: at counter 0, shift the synced line into the MSB of the shift register, shifting right. Increment bitidx and reload counter = CLOCKS_PER_BIT-1. After bitidx 7, go to STOP instead.
- STOP: at counter 0:
  - line high: rxdata <= shift register and rxvalid pulses.
  - line low: rxerror pulses and rxdata is unchanged.
  - Either way, return to IDLE.
- Re-arming needs a new falling edge. A line held low (break) after an error produces no further frames or errors.
- rxvalid and rxerror are never high in the same cycle.
- Reset (reset low at a clock edge), including mid-frame:
  - state is IDLE; rxdata = 0x00; rxvalid, rxerror and rxbusy = 0.
  - the shift register, counter and bitidx are 0, and the synchronizer flops are 1.
  - A partial frame in progress is discarded with no pulse.

## Timing
- Edge-detect cycle E = cycle in which pin rx first samples low, plus 2.
- START decision at E+HALF.
- Data bit k sampled at E+HALF+(k+1)*CLOCKS_PER_BIT, for k = 0..7.
- Stop bit sampled at E+HALF+9*CLOCKS_PER_BIT.
- rxvalid/rxerror are high exactly in cycle E+HALF+9*CLOCKS_PER_BIT+1.
- rxbusy is high from E+1 through the stop-sample cycle inclusive.
- Back-to-back frames: the next start edge can be detected in the cycle after returning to IDLE. This tolerates a stop bit shortened by up to HALF-1 clocks.
- No back-pressure: the consumer must take rxdata on the rxvalid cycle or accept overwrite by the next frame.

## Structure
- The shared package holds the state encoding (IDLE, START, DATA, STOP; 2 bits) and the frame constants: DATA_BITS = 8, STOP_LEVEL = 1, IDLE_LEVEL = 1.
- One natural sub-module, `rx_sync`: two-flop synchronizer plus falling-edge detector, with a reset value of 1.
- The rest is a single FSM module.

## Test plan
All scenarios use CLOCKS_PER_BIT=10, with stimulus driven from a behavioural 8N1 transmitter model, and reset released and rx idle high for 20 cycles first.
- Single byte 0xA5: rxvalid is high exactly one cycle, at E+96; rxdata = 0xA5; rxerror stays 0.
- Back-to-back 0x00 then 0xFF with no idle gap: two rxvalid pulses 100 cycles apart; rxdata = 0x00 then 0xFF.
- Glitch, rx low for 3 cycles then high: rxbusy pulses for ~5 cycles; no rxvalid, no rxerror; rxdata unchanged.
- Frame of 0x3C with the stop bit driven low: rxerror pulses once at the rxvalid position; rxdata keeps its previous value (0xA5). Holding rx low afterwards for 200 cycles gives no further pulses.
- Reset asserted during data bit 4 of 0x5A, then released, then 0x81 sent: outputs are 0 during reset and no pulse comes from the aborted frame; the next frame yields rxdata = 0x81.
- Stop bit shortened to 6 clocks, followed immediately by 0x12: both bytes are received correctly.

Source files
------------

// File: rtl/uart_receive_pkg.sv
// Shared types and frame constants for the 8N1 serial receiver.
// State encoding plus the line levels that define a frame.
package uart_receive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_receive_rx_sync.sv
// Two-flop synchronizer on the serial pin plus falling-edge detect.
// All flops reset to the idle line level so reset never fakes a start.
module rx_sync
  import uart_receive_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_line,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Bring the pin into the clock domain and keep one old copy.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= IDLE_LEVEL;
      r_sync <= IDLE_LEVEL;
      r_prev <= IDLE_LEVEL;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_line = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_receive.sv
// 8N1 serial receiver: frames start, 8 data bits LSB first, stop.
// Each good byte is presented with a one-cycle valid strobe.
module uart_receive
  import uart_receive_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  output logic       rxerror,
  output logic       rxbusy
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST    = 3'(DATA_BITS - 1);

  logic w_line;
  logic w_fall;
  logic w_zero;

  rx_state_t r_state, w_state_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [2:0]           r_bit, w_bit_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic [DATA_BITS-1:0] r_data, w_data_n;
  logic                 r_valid, w_valid_n;
  logic                 r_error, w_error_n;

  rx_sync u_sync (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_rx    (rx),
    .o_line  (w_line),
    .o_fall  (w_fall)
  );

  assign w_zero = (r_cnt == '0);

  // Frame sequencing: each phase waits out its counter, then samples.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_error_n = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_n = START;
          w_cnt_n   = HALF_M1;
        end
      end
      START: begin
        if (!w_zero) begin
          w_cnt_n = r_cnt - 1'b1;
        end else if (!w_line) begin
          w_state_n = DATA;
          w_cnt_n   = RELOAD;
          w_bit_n   = '0;
        end else begin
          w_state_n = IDLE;
        end
      end
      DATA: begin
        if (!w_zero) begin
          w_cnt_n = r_cnt - 1'b1;
        end else begin
          w_shift_n = {w_line, r_shift[DATA_BITS-1:1]};
          w_cnt_n   = RELOAD;
          if (r_bit == LAST) begin
            w_state_n = STOP;
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end
      end
      STOP: begin
        if (!w_zero) begin
          w_cnt_n = r_cnt - 1'b1;
        end else begin
          w_state_n = IDLE;
          if (w_line == STOP_LEVEL) begin
            w_data_n  = r_shift;
            w_valid_n = 1'b1;
          end else begin
            w_error_n = 1'b1;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_error <= w_error_n;
    end
  end

  assign rxdata  = r_data;
  assign rxvalid = r_valid;
  assign rxerror = r_error;
  assign rxbusy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: behavioural 8N1 transmitter feeding a
// scoreboard of expected bytes/errors with their arrival cycles.
module tb_uart_receive;

  localparam int CPB  = 10;
  localparam int HALF = CPB / 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       rxerror;
  logic       rxbusy;

  uart_receive #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset   (reset),
    .rx      (rx),
    .rxdata  (rxdata),
    .rxvalid (rxvalid),
    .rxerror (rxerror),
    .rxbusy  (rxbusy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_last = 8'h00;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endfunction

  task automatic drive(logic v, int n);
    rx = v;
    if (n > 0) begin
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  // Pin goes low at the next edge (cyc+1); the receiver sees the
  // edge two clocks later, samples the stop bit HALF+9*CPB after
  // that, and the strobe follows that edge.
  task automatic send(logic [7:0] d, logic stop_ok, int stop_len);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = d;
    e.at     = cyc + 1 + 2 + HALF + 9 * CPB;
    q.push_back(e);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(stop_ok, stop_len);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_rxvalid"}, rxvalid, 0);
    chk({tag, "_rxerror"}, rxerror, 0);
    chk({tag, "_rxbusy"},  rxbusy,  0);
    chk({tag, "_rxdata"},  rxdata,  0);
  endtask

  always @(negedge clock) begin
    if (reset && (rxvalid || rxerror)) begin
      chk("exclusive", rxvalid & rxerror, 0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse got v=%0b e=%0b expected none cyc=%0d",
                 rxvalid, rxerror, cyc);
      end else begin
        m_e = q.pop_front();
        chk("kind_err", rxerror, m_e.is_err);
        chk("pulse_cycle", cyc, m_e.at);
        if (!m_e.is_err) exp_last = m_e.data;
        chk("rxdata", rxdata, exp_last);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int nb;
    logic [7:0] d;
    logic [7:0] pat;
    logic ok;
    int sl;

    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("init");
    reset = 1'b1;
    drive(1'b1, 20);

    send(8'hA5, 1'b1, CPB);
    drive(1'b1, 20);

    nb = 0;
    rx = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 3) rx = 1'b1;
      @(posedge clock);
      #1;
      nb += int'(rxbusy);
    end
    chk("glitch_busy_cycles", nb, 5);
    chk("glitch_rxdata", rxdata, 8'hA5);

    send(8'h3C, 1'b0, CPB);
    drive(1'b0, 200);
    drive(1'b1, 20);
    chk("break_rxdata", rxdata, 8'hA5);

    send(8'h00, 1'b1, CPB);
    send(8'hFF, 1'b1, CPB);
    drive(1'b1, 20);

    pat = 8'h5A;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(pat[i], CPB);
    drive(pat[4], 4);
    reset = 1'b0;
    rx    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check_reset_outputs("midreset");
    end
    exp_last = 8'h00;
    reset = 1'b1;
    drive(1'b1, 20);
    send(8'h81, 1'b1, CPB);
    drive(1'b1, 20);

    send(8'hC3, 1'b1, 6);
    send(8'h12, 1'b1, CPB);
    drive(1'b1, 20);

    for (int n = 0; n < 12; n++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      sl = $urandom_range(12, 6);
      send(d, ok, sl);
      if (!ok) drive(1'b1, CPB);
      else drive(1'b1, $urandom_range(0, 5));
    end

    drive(1'b1, 50);
    chk("queue_empty", q.size(), 0);
    chk("final_rxdata", rxdata, exp_last);
    chk("final_busy", rxbusy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
